// File: rtl/dds_sweep_ctrl_if.sv
// Bus bundle between the DDS sweep controller and its host / datapath.
// master: the side that issues commands and observes the datapath words.
// slave : the sweep controller itself.
interface dds_sweep_ctrl_if #(
  parameter int FW = 16,
  parameter int PW = 8,
  parameter int DW = 16
);
  logic          start;
  logic          abort;
  logic [FW-1:0] f_start;
  logic [FW-1:0] f_stop;
  logic [FW-1:0] f_step;
  logic [DW-1:0] dwell;
  logic [PW-1:0] phase_in;
  logic          phase_ld;
  logic [FW-1:0] freq_word;
  logic [PW-1:0] phase_word;
  logic          busy;
  logic          step_strobe;
  logic          done;

  modport master (
    output start, abort, f_start, f_stop, f_step, dwell, phase_in, phase_ld,
    input  freq_word, phase_word, busy, step_strobe, done
  );

  modport slave (
    input  start, abort, f_start, f_stop, f_step, dwell, phase_in, phase_ld,
    output freq_word, phase_word, busy, step_strobe, done
  );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// DDS sweep controller: steps the frequency word linearly from f_start to
// f_stop, holding each word for max(dwell,1) cycles, and applies phase-offset
// loads glitch-free at word boundaries.
// Build option DDS_SWEEP_LOOP_EN: when defined, the sweep restarts at f_start
// after the f_stop dwell (done pulses on each restart) until aborted.
module dds_sweep_ctrl #(
  parameter int FW = 16,
  parameter int PW = 8,
  parameter int DW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  dds_sweep_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [FW-1:0] freq_word_r, freq_word_s;
  logic [PW-1:0] phase_word_r, phase_word_s;
  logic          busy_r, busy_s;
  logic          step_strobe_r, step_strobe_s;
  logic          done_r, done_s;
  logic [FW-1:0] f_stop_r, f_stop_s;
  logic [FW-1:0] f_step_r, f_step_s;
  logic [DW-1:0] reload_r, reload_s;
  logic [DW-1:0] cnt_r, cnt_s;
  logic [PW-1:0] pend_r, pend_s;
  logic          pend_vld_r, pend_vld_s;
`ifdef DDS_SWEEP_LOOP_EN
  logic [FW-1:0] f_start_r, f_start_s;
`endif

  logic [DW-1:0] dwell_m1_s;
  logic [FW:0]   sum_s;
  logic [FW-1:0] next_word_s;
  logic          last_s;
  logic [PW-1:0] pend_cur_s;
  logic          pend_cur_vld_s;

  // A zero dwell behaves as one cycle, so the counter reload is max(dwell,1)-1.
  assign dwell_m1_s = (bus.dwell == {DW{1'b0}}) ? {DW{1'b0}}
                                                : bus.dwell - {{(DW-1){1'b0}}, 1'b1};

  // Next word computed one bit wider so a large step clamps to f_stop instead of wrapping.
  assign sum_s       = {1'b0, freq_word_r} + {1'b0, f_step_r};
  assign next_word_s = (sum_s > {1'b0, f_stop_r}) ? f_stop_r : sum_s[FW-1:0];
  assign last_s      = (f_step_r == {FW{1'b0}}) || (freq_word_r >= f_stop_r);

  // A load arriving this cycle supersedes any older pending value.
  assign pend_cur_s     = bus.phase_ld ? bus.phase_in : pend_r;
  assign pend_cur_vld_s = bus.phase_ld | pend_vld_r;

  // Next-state and next-register values for the sweep sequencer.
  always_comb begin
    state_s       = state_r;
    freq_word_s   = freq_word_r;
    phase_word_s  = phase_word_r;
    busy_s        = 1'b0;
    step_strobe_s = 1'b0;
    done_s        = 1'b0;
    f_stop_s      = f_stop_r;
    f_step_s      = f_step_r;
    reload_s      = reload_r;
    cnt_s         = cnt_r;
    pend_s        = pend_r;
    pend_vld_s    = pend_vld_r;
`ifdef DDS_SWEEP_LOOP_EN
    f_start_s     = f_start_r;
`endif

    case (state_r)
      ST_IDLE: begin
        if (bus.phase_ld) begin
          phase_word_s = bus.phase_in;
        end else begin
          phase_word_s = phase_word_r;
        end
        pend_vld_s = 1'b0;
        if (bus.start && !bus.abort) begin
          state_s     = ST_RUN;
          freq_word_s = bus.f_start;
          busy_s      = 1'b1;
          f_stop_s    = bus.f_stop;
          f_step_s    = bus.f_step;
          reload_s    = dwell_m1_s;
          cnt_s       = dwell_m1_s;
`ifdef DDS_SWEEP_LOOP_EN
          f_start_s   = bus.f_start;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (bus.abort) begin
          // Leaving RUN flushes any pending phase; a coincident load wins.
          state_s = ST_IDLE;
          if (pend_cur_vld_s) begin
            phase_word_s = pend_cur_s;
          end else begin
            phase_word_s = phase_word_r;
          end
          pend_vld_s = 1'b0;
        end else begin
          busy_s     = 1'b1;
          pend_s     = pend_cur_s;
          pend_vld_s = pend_cur_vld_s;
          if (cnt_r != {DW{1'b0}}) begin
            cnt_s = cnt_r - {{(DW-1){1'b0}}, 1'b1};
          end else begin
            // Word boundary: the pending phase lands together with the word change.
            if (pend_cur_vld_s) begin
              phase_word_s = pend_cur_s;
            end else begin
              phase_word_s = phase_word_r;
            end
            pend_vld_s = 1'b0;
            if (last_s) begin
`ifdef DDS_SWEEP_LOOP_EN
              freq_word_s   = f_start_r;
              step_strobe_s = 1'b1;
              done_s        = 1'b1;
              cnt_s         = reload_r;
`else
              state_s = ST_FIN;
              busy_s  = 1'b0;
              done_s  = 1'b1;
`endif
            end else begin
              freq_word_s   = next_word_s;
              step_strobe_s = 1'b1;
              cnt_s         = reload_r;
            end
          end
        end
      end

      ST_FIN: begin
        state_s = ST_IDLE;
        if (bus.phase_ld) begin
          phase_word_s = bus.phase_in;
        end else begin
          phase_word_s = phase_word_r;
        end
        pend_vld_s = 1'b0;
      end

      default: begin
        state_s    = ST_IDLE;
        pend_vld_s = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_word_r   <= {FW{1'b0}};
      phase_word_r  <= {PW{1'b0}};
      busy_r        <= 1'b0;
      step_strobe_r <= 1'b0;
      done_r        <= 1'b0;
      f_stop_r      <= {FW{1'b0}};
      f_step_r      <= {FW{1'b0}};
      reload_r      <= {DW{1'b0}};
      cnt_r         <= {DW{1'b0}};
      pend_r        <= {PW{1'b0}};
      pend_vld_r    <= 1'b0;
`ifdef DDS_SWEEP_LOOP_EN
      f_start_r     <= {FW{1'b0}};
`endif
    end else begin
      freq_word_r   <= freq_word_s;
      phase_word_r  <= phase_word_s;
      busy_r        <= busy_s;
      step_strobe_r <= step_strobe_s;
      done_r        <= done_s;
      f_stop_r      <= f_stop_s;
      f_step_r      <= f_step_s;
      reload_r      <= reload_s;
      cnt_r         <= cnt_s;
      pend_r        <= pend_s;
      pend_vld_r    <= pend_vld_s;
`ifdef DDS_SWEEP_LOOP_EN
      f_start_r     <= f_start_s;
`endif
    end
  end

  assign bus.freq_word   = freq_word_r;
  assign bus.phase_word  = phase_word_r;
  assign bus.busy        = busy_r;
  assign bus.step_strobe = step_strobe_r;
  assign bus.done        = done_r;

endmodule
